counter_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single register port of the pulse counter subsystem (wr_en / rd_en / addr / wdata / rdata) between N_REQ independent requesters. It accepts one request at a time, drives exactly one write or read strobe to the counter register block, waits the block's read latency, and returns completion plus read data to the winning requester. It sits between software-facing masters and the counter top level.

---
 rtl/counter_bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_counter_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bus_arbiter.sv
// -----------------------------------------------------------------------------
// counter_bus_arbiter
//
// Shares the single register port of the pulse counter block between N_REQ
// requesters. One command is accepted per IDLE cycle using a round-robin
// pointer. The command drives exactly one write or read strobe. Completion and
// read data are then returned to the requester that won.
//
// Parameters
//   N_REQ   number of requesters (2..8)
//   RD_LAT  register block read latency in cycles (0..3)
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_req        per-requester request level
//   i_req_we     per-requester write (1) / read (0)
//   i_req_addr   packed 10-bit addresses, requester i at [10i+9:10i]
//   i_req_wdata  packed 32-bit write data, requester i at [32i+31:32i]
//   o_gnt        one-hot grant pulse (combinational in IDLE)
//   o_ack        one-hot completion pulse
//   o_ack_rdata  read data of the most recent completed read
//   o_busy       high whenever not IDLE
//   o_wr_en      write strobe to register block
//   o_rd_en      read strobe to register block
//   o_addr       register address (holds last command)
//   o_wdata      write data (holds last command)
//   i_rdata      read data from register block
// -----------------------------------------------------------------------------
module counter_bus_arbiter #(
    parameter int N_REQ  = 2,
    parameter int RD_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [N_REQ-1:0]     i_req_we,
    input  logic [N_REQ*10-1:0]  i_req_addr,
    input  logic [N_REQ*32-1:0]  i_req_wdata,
    output logic [N_REQ-1:0]     o_gnt,
    output logic [N_REQ-1:0]     o_ack,
    output logic [31:0]          o_ack_rdata,
    output logic                 o_busy,
    output logic                 o_wr_en,
    output logic                 o_rd_en,
    output logic [9:0]           o_addr,
    output logic [31:0]          o_wdata,
    input  logic [31:0]          i_rdata
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PW-1:0]      r_last;
    logic [PW-1:0]      r_win;
    logic [PW-1:0]      w_win;
    logic               w_any;
    logic               w_take;
    int                 w_dist;
    int                 w_best;
    logic               w_sel_we;
    logic [9:0]         w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic               w_start;
    logic               w_capture;
    logic               r_we;
    logic [9:0]         r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_ack_rdata;
    logic [N_REQ-1:0]   r_ack;
    logic               r_wr_en;
    logic               r_rd_en;
    logic               r_busy;
    logic [1:0]         r_cnt;

    // Round-robin winner: smallest circular distance from the slot after r_last.
    always_comb begin
        w_any       = 1'b0;
        w_win       = r_last;
        w_best      = N_REQ;
        w_dist      = 0;
        w_take      = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_addr  = 10'd0;
        w_sel_wdata = 32'd0;
        for (int i = 0; i < N_REQ; i++) begin
            // distance 0 is the requester right after the last winner
            w_dist      = (i + N_REQ - 1 - int'(r_last)) % N_REQ;
            w_take      = i_req[i] && (w_dist < w_best);
            w_any       = w_any | w_take;
            w_best      = w_take ? w_dist : w_best;
            w_win       = w_take ? PW'(i) : w_win;
            w_sel_we    = w_take ? i_req_we[i] : w_sel_we;
            w_sel_addr  = w_take ? i_req_addr[i*10 +: 10] : w_sel_addr;
            w_sel_wdata = w_take ? i_req_wdata[i*32 +: 32] : w_sel_wdata;
        end
    end

    // Next-state decode plus accept/capture qualifiers.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next  = S_ISSUE;
                    w_start = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_next = S_ACK;
                end else if (RD_LAT == 0) begin
                    // zero-latency block: data is valid alongside the strobe
                    w_next    = S_ACK;
                    w_capture = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 2'(RD_LAT - 1)) begin
                    w_next    = S_ACK;
                    w_capture = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_ACK: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command latch, strobes, latency counter, completion and read data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last      <= PW'(N_REQ - 1);
            r_win       <= {PW{1'b0}};
            r_we        <= 1'b0;
            r_addr      <= 10'd0;
            r_wdata     <= 32'd0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_cnt       <= 2'd0;
            r_ack       <= {N_REQ{1'b0}};
            r_ack_rdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            if (w_start) begin
                r_last  <= w_win;
                r_win   <= w_win;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            // strobes are high only in the single ISSUE cycle after acceptance
            r_wr_en <= w_start & w_sel_we;
            r_rd_en <= w_start & ~w_sel_we;
            if (r_state == S_ISSUE) begin
                r_cnt <= 2'd0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_capture) begin
                r_ack_rdata <= i_rdata;
            end
            r_ack  <= (w_next == S_ACK) ? (N_REQ'(1) << r_win) : {N_REQ{1'b0}};
            r_busy <= (w_next != S_IDLE);
        end
    end

    assign o_gnt       = ((r_state == S_IDLE) && w_any) ? (N_REQ'(1) << w_win) : {N_REQ{1'b0}};
    assign o_ack       = r_ack;
    assign o_ack_rdata = r_ack_rdata;
    assign o_busy      = r_busy;
    assign o_wr_en     = r_wr_en;
    assign o_rd_en     = r_rd_en;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;

endmodule

// File: tb/tb_counter_bus_arbiter.sv
// Bench for counter_bus_arbiter: four instances (RD_LAT 0..3) share the
// stimulus. Every cycle each instance is compared against a transaction-level
// timing model. A directed vector table and hand sequences add constant checks.
module tb_counter_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  req_we = 2'b00;
    logic [19:0] req_addr = 20'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [31:0] rdata = 32'd0;

    logic [1:0]  gnt_o   [4];
    logic [1:0]  ack_o   [4];
    logic [31:0] ard_o   [4];
    logic        busy_o  [4];
    logic        wr_o    [4];
    logic        rd_o    [4];
    logic [9:0]  addr_o  [4];
    logic [31:0] wdata_o [4];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] hist [0:4095];

    // transaction-level model state, one per latency
    bit          m_act   [4];
    int          m_tg    [4];
    int          m_done  [4];
    int          m_win   [4];
    int          m_last  [4];
    bit          m_we    [4];
    logic [9:0]  m_caddr [4];
    logic [31:0] m_cwd   [4];
    logic [9:0]  m_oaddr [4];
    logic [31:0] m_owd   [4];
    logic [31:0] m_ard   [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        counter_bus_arbiter #(.N_REQ(2), .RD_LAT(g)) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_req       (req),
            .i_req_we    (req_we),
            .i_req_addr  (req_addr),
            .i_req_wdata (req_wdata),
            .o_gnt       (gnt_o[g]),
            .o_ack       (ack_o[g]),
            .o_ack_rdata (ard_o[g]),
            .o_busy      (busy_o[g]),
            .o_wr_en     (wr_o[g]),
            .o_rd_en     (rd_o[g]),
            .o_addr      (addr_o[g]),
            .o_wdata     (wdata_o[g]),
            .i_rdata     (rdata)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            m_act[l]   = 1'b0;
            m_last[l]  = 1;
            m_oaddr[l] = 10'd0;
            m_owd[l]   = 32'd0;
            m_ard[l]   = 32'd0;
        end
    endtask

    // Apply the timing rules for cycle c to every latency and compare.
    task automatic model_check(input int c);
        for (int l = 0; l < 4; l++) begin
            logic [1:0] eg;
            logic [1:0] ea;
            int idx;
            if (m_act[l] && c == m_tg[l] + 1) begin
                m_oaddr[l] = m_caddr[l];
                m_owd[l]   = m_cwd[l];
            end
            if (m_act[l] && !m_we[l] && c == m_done[l]) m_ard[l] = hist[m_tg[l] + 1 + l];
            if (m_act[l] && c > m_done[l]) m_act[l] = 1'b0;
            eg = 2'b00;
            if (!m_act[l]) begin
                for (int k = 1; k <= 2; k++) begin
                    int cand;
                    cand = (m_last[l] + k) % 2;
                    if (eg == 2'b00 && ((cand == 1) ? req[1] : req[0])) begin
                        eg  = (cand == 1) ? 2'b10 : 2'b01;
                        idx = cand;
                    end
                end
                if (eg != 2'b00) begin
                    m_act[l]   = 1'b1;
                    m_tg[l]    = c;
                    m_win[l]   = idx;
                    m_last[l]  = idx;
                    m_we[l]    = (idx == 1) ? req_we[1] : req_we[0];
                    m_caddr[l] = (idx == 1) ? req_addr[19:10] : req_addr[9:0];
                    m_cwd[l]   = (idx == 1) ? req_wdata[63:32] : req_wdata[31:0];
                    m_done[l]  = c + 2 + (m_we[l] ? 0 : l);
                end
            end
            ea = (m_act[l] && c == m_done[l]) ? ((m_win[l] == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("L%0d_gnt", l),   32'(gnt_o[l]), 32'(eg));
            chk($sformatf("L%0d_ack", l),   32'(ack_o[l]), 32'(ea));
            chk($sformatf("L%0d_wr_en", l), 32'(wr_o[l]),
                32'(m_act[l] && m_we[l] && c == m_tg[l] + 1));
            chk($sformatf("L%0d_rd_en", l), 32'(rd_o[l]),
                32'(m_act[l] && !m_we[l] && c == m_tg[l] + 1));
            chk($sformatf("L%0d_busy", l),  32'(busy_o[l]),
                32'(m_act[l] && c > m_tg[l] && c <= m_done[l]));
            chk($sformatf("L%0d_addr", l),  32'(addr_o[l]), 32'(m_oaddr[l]));
            chk($sformatf("L%0d_wdata", l), wdata_o[l], m_owd[l]);
            chk($sformatf("L%0d_ack_rdata", l), ard_o[l], m_ard[l]);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later.
    task automatic tick(input logic [1:0] r, input logic [1:0] w, input logic [19:0] a,
                        input logic [63:0] d, input logic [31:0] rd);
        @(negedge clk);
        req = r; req_we = w; req_addr = a; req_wdata = d; rdata = rd;
        hist[cyc] = rd;
        #1;
        if (rst) model_reset();
        else model_check(cyc);
        cyc++;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [19:0] addr;
        logic [63:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic [1:0]  e_ack;
        logic        e_wr;
        logic        e_rd;
        logic        e_busy;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_ard;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [1:0] rq;
        // single write from 0, single read from 1, then a write after the read
        tbl[0]  = '{2'b01, 2'b01, 20'h00004, 64'h1,    32'h0,        2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0,    32'h0};
        tbl[1]  = '{2'b00, 2'b00, 20'h0,     64'h0,    32'h0,        2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 10'h004, 32'h1,    32'h0};
        tbl[2]  = '{2'b00, 2'b00, 20'h0,     64'h0,    32'h0,        2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 10'h004, 32'h1,    32'h0};
        tbl[3]  = '{2'b00, 2'b00, 20'h0,     64'h0,    32'h0,        2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 10'h004, 32'h1,    32'h0};
        tbl[4]  = '{2'b10, 2'b00, 20'h02000, 64'h0,    32'h0,        2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 10'h004, 32'h1,    32'h0};
        tbl[5]  = '{2'b00, 2'b00, 20'h0,     64'h0,    32'hA5A50002, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 10'h008, 32'h0,    32'h0};
        tbl[6]  = '{2'b00, 2'b00, 20'h0,     64'h0,    32'hA5A50003, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 10'h008, 32'h0,    32'h0};
        tbl[7]  = '{2'b00, 2'b00, 20'h0,     64'h0,    32'hA5A50004, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 10'h008, 32'h0,    32'hA5A50003};
        tbl[8]  = '{2'b00, 2'b00, 20'h0,     64'h0,    32'hA5A50005, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 10'h008, 32'h0,    32'hA5A50003};
        tbl[9]  = '{2'b01, 2'b01, 20'h00010, 64'hDEAD, 32'h0,        2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 10'h008, 32'h0,    32'hA5A50003};
        tbl[10] = '{2'b00, 2'b00, 20'h0,     64'h0,    32'h0,        2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 10'h010, 32'hDEAD, 32'hA5A50003};
        tbl[11] = '{2'b00, 2'b00, 20'h0,     64'h0,    32'h0,        2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 10'h010, 32'hDEAD, 32'hA5A50003};
        tbl[12] = '{2'b00, 2'b00, 20'h0,     64'h0,    32'h0,        2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 10'h010, 32'hDEAD, 32'hA5A50003};

        // reset, then the idle state after release
        tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        rst = 1'b0;
        tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        chk("rst_gnt",   32'(gnt_o[1]),  32'h0);
        chk("rst_ack",   32'(ack_o[1]),  32'h0);
        chk("rst_busy",  32'(busy_o[1]), 32'h0);
        chk("rst_wr_en", 32'(wr_o[1]),   32'h0);
        chk("rst_rd_en", 32'(rd_o[1]),   32'h0);
        chk("rst_addr",  32'(addr_o[1]), 32'h0);
        chk("rst_wdata", wdata_o[1],     32'h0);
        chk("rst_ard",   ard_o[1],       32'h0);

        // directed vectors against the RD_LAT=1 instance
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
            chk($sformatf("v%0d_gnt", i),   32'(gnt_o[1]),  32'(tbl[i].e_gnt));
            chk($sformatf("v%0d_ack", i),   32'(ack_o[1]),  32'(tbl[i].e_ack));
            chk($sformatf("v%0d_wr_en", i), 32'(wr_o[1]),   32'(tbl[i].e_wr));
            chk($sformatf("v%0d_rd_en", i), 32'(rd_o[1]),   32'(tbl[i].e_rd));
            chk($sformatf("v%0d_busy", i),  32'(busy_o[1]), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d_addr", i),  32'(addr_o[1]), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d_wdata", i), wdata_o[1],     tbl[i].e_wdata);
            chk($sformatf("v%0d_ard", i),   ard_o[1],       tbl[i].e_ard);
        end
        // latency sweep: each instance holds the word seen RD_LAT cycles after rd_en
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("sweep_L%0d_ard", l), ard_o[l], 32'hA5A50002 + 32'(l));
        end

        // contention from reset: writes alternate 0,1,0,1 every 3 cycles
        rst = 1'b1;
        tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(2'b11, 2'b11, 20'($urandom), {$urandom, $urandom}, $urandom);
            if (k % 3 == 0) chk($sformatf("cont%0d_gnt", k), 32'(gnt_o[1]),
                                ((k / 3) % 2 == 1) ? 32'h2 : 32'h1);
            else chk($sformatf("cont%0d_gnt", k), 32'(gnt_o[1]), 32'h0);
        end
        for (int k = 0; k < 3; k++) tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);

        // withdrawal: requester 1 pulses only while requester 0 is in ISSUE
        tick(2'b01, 2'b01, 20'h00020, 64'h55, 32'h0);
        chk("wd_gnt0", 32'(gnt_o[1]), 32'h1);
        tick(2'b10, 2'b00, 20'h0, 64'h0, 32'h0);
        chk("wd_issue_gnt", 32'(gnt_o[1]), 32'h0);
        tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        chk("wd_ack0", 32'(ack_o[1]), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
            chk($sformatf("wd_idle%0d_gnt", k), 32'(gnt_o[1]), 32'h0);
            chk($sformatf("wd_idle%0d_ack", k), 32'(ack_o[1]), 32'h0);
        end

        // reset while the RD_LAT=3 instance waits on a read
        tick(2'b01, 2'b00, 20'h00030, 64'h0, 32'h0);
        tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        chk("rw_busy_before", 32'(busy_o[3]), 32'h1);
        rst = 1'b1;
        #1;
        chk("rw_busy_now", 32'(busy_o[3]), 32'h0);
        chk("rw_rd_en_now", 32'(rd_o[3]), 32'h0);
        tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) tick(2'b00, 2'b00, 20'h0, 64'h0, 32'h0);
        tick(2'b11, 2'b00, 20'($urandom), 64'h0, 32'h0);
        chk("rw_first_gnt", 32'(gnt_o[1]), 32'h1);
        for (int k = 0; k < 6; k++) tick(2'b00, 2'b00, 20'h0, 64'h0, $urandom);

        // random traffic against the model
        rq = 2'b00;
        for (int k = 0; k < 600; k++) begin
            rq[0] = rq[0] ^ ($urandom_range(0, 3) == 0);
            rq[1] = rq[1] ^ ($urandom_range(0, 3) == 0);
            tick(rq, 2'($urandom), 20'($urandom), {$urandom, $urandom}, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
